io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-master arbiter and transaction sequencer in front of the 8-device IO hub (device window 0x00007800–0x00007fff). It lets the CPU data port (master 0) and a second bus master (master 1, DMA/debug) share the single hub port. Each access is held on the hub for a fixed number of cycles, then acknowledged with registered read data. Round-robin fairness applies by default; an optional lock feature allows back-to-back ownership.

## Interface
Parameters:
- ACCESS_CYCLES, default 1: cycles each access is held on the hub; legal range 1..16.
- CNT_W, default 4: width of the access counter; must satisfy 2^CNT_W ≥ ACCESS_CYCLES.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_lock, m1_lock  in  1  ownership-hold hint; ignored unless IOARB_LOCK_EN is defined.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  read data; valid while the matching ack is high.
- bus_addr  out  32  to hub soc_addr.
- bus_wdata  out  32  to hub soc_out.
- bus_we  out  1  to hub bus_we.
- bus_rdata  in  32  from hub soc_in.
- busy  out  1  high in ACC and DONE.
- gnt  out  1  index of the current or most recent owner.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a master, latch its we/addr/wdata into registers, set cnt=0, go to ACC.
- Selection rule:
  - Single requester wins.
  - Both requesting: the master other than last_gnt wins (round-robin).
- ACC:
  - bus_addr and bus_wdata are driven from the latched registers.
  - bus_we = latched_we AND (cnt==0). Writes therefore pulse exactly once per transaction, which is safe for FIFO-style devices.
  - cnt increments each cycle.
  - When cnt==ACCESS_CYCLES-1: capture bus_rdata into the rdata register, go to DONE.
- DONE:
  - Assert ack of the granted master for exactly one cycle.
  - Drive that master's rdata from the register; the other master's rdata reads 0.
  - Update last_gnt to the granted master; go to IDLE.
- Read data is captured for writes as well; the requester ignores it.
- Requester rules:
  - The requester may change or drop req only in the cycle after it sees ack.
  - Dropping req before ack is a protocol violation. The transaction still completes and acks; the arbiter does not abort.
- Outputs of the idle master: ack=0, rdata=0.
- Address decoding is not performed here. Any address is forwarded; the hub qualifies the write enable.

## Timing
- Request sampled high in IDLE at cycle T:
  - Bus driven in cycles T+1 .. T+ACCESS_CYCLES.
  - bus_we, if a write, high at T+1 only.
  - Read data sampled at the end of cycle T+ACCESS_CYCLES.
  - ack at T+ACCESS_CYCLES+1.
  - IDLE again at T+ACCESS_CYCLES+2.
- Minimum transaction period: ACCESS_CYCLES+2 cycles. With ACCESS_CYCLES=1, one transaction every 3 cycles.
- Reset values: state=IDLE, cnt=0, last_gnt=1 (master 0 wins the first tie), gnt=0, busy=0, bus_we=0, bus_addr=0, bus_wdata=0, all acks 0, all rdata 0.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately (asynchronous reset).
  - No ack is issued; the requester reissues after reset.
- Simultaneous events:
  - A new request from the non-owner during ACC or DONE waits; it is evaluated in the following IDLE.
  - Both masters re-requesting continuously alternate grants 0,1,0,1.

## Configuration
- IOARB_LOCK_EN defined:
  - In IDLE, if last_gnt's req and lock are both high, last_gnt wins regardless of the other master.
  - Lock sampled low, or req low, releases ownership; normal round-robin resumes.
- IOARB_LOCK_EN undefined: the m*_lock inputs are unconnected and pure round-robin applies.

## Structure
- Shared package io_arb_pkg:
  - State encoding enum (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
  - Master index constants M_CPU=1'b0, M_AUX=1'b1.
  - IO window base constant 32'h0000_7800.
- One natural sub-module, io_arb_rr2: combinational two-way pick from req[1:0], last_gnt, and lock (lock only under IOARB_LOCK_EN); outputs sel and any_req.
- FSM, counter, latches, and output muxing live in io_bus_arbiter.

## Test plan
- Single read, ACCESS_CYCLES=1:
  - Stimulus: m0 reads 0x7804, bus_rdata=0xDEADBEEF.
  - Response: bus_addr=0x7804 at T+1; m0_ack and m0_rdata=0xDEADBEEF at T+2; bus_we never high.
- Write, ACCESS_CYCLES=3:
  - Stimulus: m1 writes 0x12345678 to 0x7A10.
  - Response: bus_we high only at T+1; bus_addr held through T+3; m1_ack at T+4.
- Tie from reset:
  - Stimulus: both masters request continuously.
  - Response: grant order 0,1,0,1 (gnt toggles per transaction); each ack coincides with its own master only.
- Reset mid-ACC:
  - Stimulus: assert rst_n=0 at T+2 with ACCESS_CYCLES=4.
  - Response: bus_we, busy, and acks are 0 immediately; no ack after release; the next request proceeds normally with m0 winning a tie.
- Lock with IOARB_LOCK_EN:
  - Stimulus: m0_lock=1 and both masters requesting.
  - Response: m0 granted three consecutive times; m0_lock drops; m1 granted next.
- Early drop:
  - Stimulus: m0 drops req during ACC.
  - Response: transaction still completes and m0_ack pulses once.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master IO hub arbiter.
// Lock support is compiled in only when IOARB_LOCK_EN is defined.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam logic [31:0] IO_BASE = 32'h0000_7800;

endpackage

// File: rtl/io_arb_rr2.sv
// Two-way round-robin pick; with IOARB_LOCK_EN the last owner may
// keep the bus while it holds req and lock.
module io_arb_rr2
    import io_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
`ifdef IOARB_LOCK_EN
    input  logic [1:0] lock,
`endif
    output logic       sel,
    output logic       any_req
);

    logic hold;

`ifdef IOARB_LOCK_EN
    assign hold = req[last_gnt] & lock[last_gnt];
`else
    assign hold = 1'b0;
`endif

    assign any_req = |req;

    always_comb begin
        sel = M_CPU;
        if (hold) begin
            sel = last_gnt;
        end else if (&req) begin
            sel = ~last_gnt;
        end else if (req[1]) begin
            sel = M_AUX;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and sequencer for the IO hub port.
// Optional ownership lock is enabled by defining IOARB_LOCK_EN.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic        m0_lock,
    input  logic        m1_lock,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        gnt
);

    arb_state_e       state;
    arb_state_e       nxt;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [31:0]      rdata_q;
    logic             own;
    logic             last_gnt;
    logic             sel;
    logic             any_req;
    logic             cnt_last;

    io_arb_rr2 u_rr2 (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt),
`ifdef IOARB_LOCK_EN
        .lock     ({m1_lock, m0_lock}),
`endif
        .sel      (sel),
        .any_req  (any_req)
    );

`ifndef IOARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
`endif

    assign cnt_last = (cnt == CNT_W'(ACCESS_CYCLES - 1));

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (any_req) nxt = ACC;
            ACC:     if (cnt_last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            own       <= M_CPU;
            last_gnt  <= M_AUX;
        end else begin
            state <= nxt;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        own       <= sel;
                        lat_we    <= sel ? m1_we : m0_we;
                        lat_addr  <= sel ? m1_addr : m0_addr;
                        lat_wdata <= sel ? m1_wdata : m0_wdata;
                        cnt       <= '0;
                    end
                end
                ACC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last) rdata_q <= bus_rdata;
                end
                DONE:    last_gnt <= own;
                default: ;
            endcase
        end
    end

    // Write enable only on the first hold cycle so FIFO devices see one push.
    assign bus_we    = (state == ACC) && lat_we && (cnt == '0);
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign busy      = (state != IDLE);
    assign gnt       = own;

    assign m0_ack   = (state == DONE) && (own == M_CPU);
    assign m1_ack   = (state == DONE) && (own == M_AUX);
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: vector table, ack scoreboard,
// and hand sequences for ties, lock, early drop and mid-access reset.
module tb_io_bus_arbiter;

    localparam int AC = 3;

    typedef struct packed {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct packed {
        logic        m;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, bus_we, busy, gnt;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [31:0] hub_data;

    int   errors = 0;
    int   checks = 0;
    int   acks_seen = 0;
    exp_t sb_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Hub model: read data depends on the address the arbiter presents.
    assign bus_rdata = hub_data + bus_addr;

    io_bus_arbiter #(.ACCESS_CYCLES(AC), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_we     (m0_we),
        .m1_we     (m1_we),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
        .m0_ack    (m0_ack),
        .m1_ack    (m1_ack),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .gnt       (gnt)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    // Scoreboard: every ack pops one expected {master, rdata}.
    always @(negedge clk) begin
        exp_t e;
        logic am;
        if (rst_n) begin
            if (m0_ack || m1_ack) begin
                am = m1_ack;
                check("single_ack", 32'(m0_ack & m1_ack), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: m%0d acked, none due", am);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_master", 32'(am), 32'(e.m));
                    check("ack_rdata", am ? m1_rdata : m0_rdata, e.rd);
                    check("other_rdata", am ? m0_rdata : m1_rdata, 32'd0);
                    check("ack_gnt", 32'(gnt), 32'(am));
                    acks_seen++;
                end
            end else begin
                check("quiet_rdata", m0_rdata | m1_rdata, 32'd0);
            end
        end
    end

    task automatic wait_acks(input int n);
        int target;
        int k;
        target = acks_seen + n;
        k = 0;
        while (acks_seen < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("ack_wait", 32'(acks_seen >= target), 32'd1);
    endtask

    task automatic run_one(input vec_t v, input bit early);
        int  n;
        int  we_at;
        int  we_cnt;
        bit  got;
        @(posedge clk);
        #1;
        hub_data = v.rdata - v.addr;
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        sb_q.push_back('{m: v.m, rd: v.rdata});
        n = 0; we_at = 0; we_cnt = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (m0_ack || m1_ack) begin
                got = 1;
            end else if (busy) begin
                check("bus_addr", bus_addr, v.addr);
                check("bus_wdata", bus_wdata, v.wdata);
                if (bus_we) begin
                    we_cnt++;
                    we_at = n;
                end
            end
            if (early && n == 3) drive(v.m, 1'b0, 1'b0, '0, '0);
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(n), 32'(AC + 2));
        check("we_pulses", 32'(we_cnt), v.we ? 32'd1 : 32'd0);
        check("we_cycle", 32'(we_at), v.we ? 32'd2 : 32'd0);
        @(posedge clk);
        #1;
        drive(v.m, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic tie_start;
        @(posedge clk);
        #1;
        hub_data = 32'h1000_0000;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_7820, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_7840, 32'h0);
    endtask

    task automatic tie_stop;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push_tie(input logic m);
        sb_q.push_back('{m: m, rd: m ? 32'h1000_7840 : 32'h1000_7820});
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_7804, 32'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_7A10, 32'h1234_5678, 32'hCAFE_0001};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_7FFC, 32'hA5A5_A5A5, 32'h1111_2222};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_7800, 32'h0, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h55AA_55AA};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_7FFF, 32'h0, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        hub_data = '0;
        m0_lock = 1'b0;
        m1_lock = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie from reset: m0 first, then strict alternation.
        push_tie(1'b0); push_tie(1'b1); push_tie(1'b0); push_tie(1'b1);
        tie_start();
        wait_acks(4);
        tie_stop();

        for (int i = 0; i < 6; i++) run_one(vecs[i], 1'b0);

        // Lock hint with both masters requesting.
        push_tie(1'b0);
`ifdef IOARB_LOCK_EN
        push_tie(1'b0); push_tie(1'b0);
`else
        push_tie(1'b1); push_tie(1'b0);
`endif
        m0_lock = 1'b1;
        tie_start();
        wait_acks(3);
        @(posedge clk);
        #1;
        m0_lock = 1'b0;
        push_tie(1'b1);
        wait_acks(1);
        tie_stop();

        run_one('{1'b0, 1'b0, 32'h0000_7830, 32'h0, 32'h0BAD_0BAD}, 1'b1);

        // Reset two cycles into a hold: no ack may follow.
        @(posedge clk);
        #1;
        hub_data = 32'h0;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_7808, 32'h0000_00AA);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_we", 32'(bus_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (AC + 4) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        push_tie(1'b0); push_tie(1'b1);
        tie_start();
        wait_acks(2);
        tie_stop();

        repeat (AC + 4) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
